// File: rtl/bank_stream_mux.sv
// Routes one of NUM_SRC lane banks onto a registered valid/ready stream, switching banks only between packets.
// Optional packet counter is built when BANK_STREAM_MUX_PKT_CNT_EN is defined.
module bank_stream_mux #(
  parameter int WIDTH   = 32,
  parameter int LANES   = 16,
  parameter int NUM_SRC = 2,
  parameter int SEL_W   = 1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_SRC*LANES*WIDTH-1:0] in_data,
  input  logic [NUM_SRC-1:0]             in_valid,
  input  logic [NUM_SRC-1:0]             in_last,
  output logic [NUM_SRC-1:0]             in_ready,
  input  logic [SEL_W-1:0]               sel_req,
  input  logic                           sel_req_valid,
  output logic                           sel_req_ready,
  output logic [SEL_W-1:0]               sel_cur,
  output logic                           sel_err,
  output logic [LANES*WIDTH-1:0]         out_data,
  output logic                           out_valid,
  output logic                           out_last,
  input  logic                           out_ready,
  output logic [15:0]                    pkt_count
);

  localparam int BEAT_W = LANES * WIDTH;

  typedef enum logic [1:0] {IDLE, BUSY, SWITCH} state_e;

  state_e              state_q, state_d;
  logic [SEL_W-1:0]    selCur_q, pendSel_q;
  logic                pendValid_q;
  logic                selErr_q;
  logic [BEAT_W-1:0]   outData_q;
  logic                outValid_q, outLast_q;

  logic [BEAT_W-1:0]   curData;
  logic                curValid, curLast;
  logic                reqFire, reqOob, newPend, pendAny;
  logic                outFree, readyCur, accept, switchDone;

  // Pick the currently routed bank's beat and handshake bits
  always_comb begin
    curData  = '0;
    curValid = 1'b0;
    curLast  = 1'b0;
    for (int s = 0; s < NUM_SRC; s++) begin
      if (selCur_q == SEL_W'(s)) begin
        curData  = in_data[s*BEAT_W +: BEAT_W];
        curValid = in_valid[s];
        curLast  = in_last[s];
      end
    end
  end

  assign reqFire = sel_req_valid & ~pendValid_q;
  assign reqOob  = 32'(sel_req) >= 32'(NUM_SRC);
  assign newPend = reqFire & ~reqOob & (sel_req != selCur_q);
  // A request arriving with the last beat must still block the old bank next cycle
  assign pendAny = pendValid_q | newPend;

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept && !curLast) state_d = BUSY;
        else if (pendAny)       state_d = SWITCH;
      end
      BUSY: begin
        if (accept && curLast) state_d = pendAny ? SWITCH : IDLE;
      end
      SWITCH: begin
        if (outFree) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    outFree    = ~outValid_q | out_ready;
    readyCur   = outFree & (state_q != SWITCH);
    accept     = curValid & readyCur;
    switchDone = (state_q == SWITCH) & outFree;
    in_ready   = '0;
    for (int s = 0; s < NUM_SRC; s++) begin
      if (selCur_q == SEL_W'(s)) in_ready[s] = readyCur;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      outData_q   <= '0;
      outValid_q  <= 1'b0;
      outLast_q   <= 1'b0;
      selCur_q    <= '0;
      pendSel_q   <= '0;
      pendValid_q <= 1'b0;
      selErr_q    <= 1'b0;
    end else begin
      if (accept) begin
        outData_q  <= curData;
        outLast_q  <= curLast;
        outValid_q <= 1'b1;
      end else if (out_ready) begin
        outValid_q <= 1'b0;
      end
      selErr_q <= reqFire & reqOob;
      if (switchDone) begin
        selCur_q    <= pendSel_q;
        pendValid_q <= 1'b0;
      end else if (newPend) begin
        pendSel_q   <= sel_req;
        pendValid_q <= 1'b1;
      end
    end
  end

`ifdef BANK_STREAM_MUX_PKT_CNT_EN
  logic [15:0] pktCount_q;

  always_ff @(posedge clk) begin
    if (rst)                                pktCount_q <= '0;
    else if (outValid_q & out_ready & outLast_q) pktCount_q <= pktCount_q + 16'd1;
  end

  assign pkt_count = pktCount_q;
`else
  assign pkt_count = '0;
`endif

  assign sel_req_ready = ~pendValid_q;
  assign sel_cur       = selCur_q;
  assign sel_err       = selErr_q;
  assign out_data      = outData_q;
  assign out_valid     = outValid_q;
  assign out_last      = outLast_q;

endmodule

// File: tb/tb_bank_stream_mux.sv
// Directed bench for bank_stream_mux: a default 2x16x32 instance plus a 3-bank instance for range checks.
module tb_bank_stream_mux;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [1023:0] inData1;
  logic [1:0]    inValid1, inLast1, inReady1;
  logic          selReq1, selReqValid1, selReqReady1, selCur1, selErr1;
  logic [511:0]  outData1;
  logic          outValid1, outLast1, outReady1;
  logic [15:0]   pktCount1;

  logic [47:0]   inData2;
  logic [2:0]    inValid2, inLast2, inReady2;
  logic [1:0]    selReq2, selCur2;
  logic          selReqValid2, selReqReady2, selErr2;
  logic [15:0]   outData2;
  logic          outValid2, outLast2, outReady2;
  logic [15:0]   pktCount2;

  int tests  = 0;
  int failed = 0;

  bank_stream_mux dut (
    .clk(clk), .rst(rst), .in_data(inData1), .in_valid(inValid1), .in_last(inLast1),
    .in_ready(inReady1), .sel_req(selReq1), .sel_req_valid(selReqValid1),
    .sel_req_ready(selReqReady1), .sel_cur(selCur1), .sel_err(selErr1),
    .out_data(outData1), .out_valid(outValid1), .out_last(outLast1),
    .out_ready(outReady1), .pkt_count(pktCount1)
  );

  bank_stream_mux #(.WIDTH(8), .LANES(2), .NUM_SRC(3), .SEL_W(2)) dut3 (
    .clk(clk), .rst(rst), .in_data(inData2), .in_valid(inValid2), .in_last(inLast2),
    .in_ready(inReady2), .sel_req(selReq2), .sel_req_valid(selReqValid2),
    .sel_req_ready(selReqReady2), .sel_cur(selCur2), .sel_err(selErr2),
    .out_data(outData2), .out_valid(outValid2), .out_last(outLast2),
    .out_ready(outReady2), .pkt_count(pktCount2)
  );

  task automatic checkOutput(input string tag, input logic [511:0] got, input logic [511:0] exp);
    tests++;
    if (got !== exp) begin
      failed++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic nextCycle();
    @(negedge clk);
  endtask

  function automatic logic [511:0] makeBeat(input logic [31:0] base);
    logic [511:0] beat;
    for (int l = 0; l < 16; l++) beat[l*32 +: 32] = base + 32'(l);
    return beat;
  endfunction

  initial begin
    rst = 1'b1;
    inData1 = '0; inValid1 = '0; inLast1 = '0; selReq1 = 1'b0; selReqValid1 = 1'b0; outReady1 = 1'b1;
    inData2 = '0; inValid2 = '0; inLast2 = '0; selReq2 = '0;   selReqValid2 = 1'b0; outReady2 = 1'b1;
    repeat (3) nextCycle();
    rst = 1'b0;
    #1;
    checkOutput("rst_out_valid", outValid1, 0);
    checkOutput("rst_out_last", outLast1, 0);
    checkOutput("rst_out_data", outData1, 0);
    checkOutput("rst_sel_cur", selCur1, 0);
    checkOutput("rst_sel_err", selErr1, 0);
    checkOutput("rst_req_ready", selReqReady1, 1);
    checkOutput("rst_pkt_count", pktCount1, 0);

    // 4-beat packet on bank0, full throughput
    for (int b = 1; b <= 4; b++) begin
      inValid1 = 2'b01;
      inLast1  = {1'b0, b == 4};
      inData1[511:0] = makeBeat(32'h100 + 32'(b - 1) * 32'h1000);
      #1;
      checkOutput("t1_in_ready", inReady1, 2'b01);
      if (b > 1) begin
        checkOutput("t1_data", outData1, makeBeat(32'h100 + 32'(b - 2) * 32'h1000));
        checkOutput("t1_valid", outValid1, 1);
        checkOutput("t1_last", outLast1, 0);
      end
      nextCycle();
    end
    inValid1 = 2'b00; inLast1 = 2'b00;
    #1;
    checkOutput("t1_data4", outData1, makeBeat(32'h3100));
    checkOutput("t1_last4", outLast1, 1);
    nextCycle(); #1;
    checkOutput("t1_drain", outValid1, 0);

    // mid-packet switch to bank1, bank1 offering a single-beat packet all along
    inData1[1023:512] = makeBeat(32'hA5A5_0000);
    inValid1 = 2'b11; inLast1 = 2'b10; inData1[511:0] = makeBeat(32'h200);
    #1; checkOutput("t2_rdy0", inReady1, 2'b01);
    nextCycle();
    inData1[511:0] = makeBeat(32'h1200);
    #1; checkOutput("t2_b1", outData1, makeBeat(32'h200));
    nextCycle();
    inData1[511:0] = makeBeat(32'h2200); selReq1 = 1'b1; selReqValid1 = 1'b1;
    #1;
    checkOutput("t2_req_rdy", selReqReady1, 1);
    checkOutput("t2_b2", outData1, makeBeat(32'h1200));
    nextCycle();
    selReqValid1 = 1'b0; inData1[511:0] = makeBeat(32'h3200); inLast1 = 2'b11;
    #1;
    checkOutput("t2_pend", selReqReady1, 0);
    checkOutput("t2_rdy3", inReady1, 2'b01);
    checkOutput("t2_b3", outData1, makeBeat(32'h2200));
    nextCycle();
    inValid1 = 2'b10;
    #1;
    checkOutput("t2_gap", inReady1, 2'b00);
    checkOutput("t2_sel_old", selCur1, 0);
    checkOutput("t2_b4", outData1, makeBeat(32'h3200));
    checkOutput("t2_last4", outLast1, 1);
    nextCycle(); #1;
    checkOutput("t2_sel_new", selCur1, 1);
    checkOutput("t2_rdy_new", inReady1, 2'b10);
    checkOutput("t2_bubble", outValid1, 0);
    checkOutput("t2_req_free", selReqReady1, 1);
    nextCycle();
    inValid1 = 2'b00; inLast1 = 2'b00;
    #1;
    checkOutput("t2_bank1", outData1, makeBeat(32'hA5A5_0000));
    checkOutput("t2_bank1_last", outLast1, 1);
    checkOutput("t2_bank1_valid", outValid1, 1);
    nextCycle();

    // back-pressure on bank1
    inValid1 = 2'b10; inLast1 = 2'b00; inData1[1023:512] = makeBeat(32'h300);
    #1; checkOutput("t3_rdy", inReady1, 2'b10);
    nextCycle();
    outReady1 = 1'b0; inData1[1023:512] = makeBeat(32'h1300); inLast1 = 2'b10;
    for (int c = 0; c < 3; c++) begin
      #1;
      checkOutput("t3_hold_data", outData1, makeBeat(32'h300));
      checkOutput("t3_hold_valid", outValid1, 1);
      checkOutput("t3_hold_rdy", inReady1, 2'b00);
      nextCycle();
    end
    outReady1 = 1'b1;
    #1;
    checkOutput("t3_rel_rdy", inReady1, 2'b10);
    checkOutput("t3_rel_data", outData1, makeBeat(32'h300));
    nextCycle();
    inValid1 = 2'b00; inLast1 = 2'b00;
    #1;
    checkOutput("t3_next", outData1, makeBeat(32'h1300));
    checkOutput("t3_next_last", outLast1, 1);
    nextCycle(); #1;
    checkOutput("t3_empty", outValid1, 0);

    // out-of-range and valid requests on the 3-bank instance
    selReq2 = 2'd3; selReqValid2 = 1'b1;
    #1; checkOutput("t4_req_rdy", selReqReady2, 1);
    nextCycle();
    selReqValid2 = 1'b0;
    #1;
    checkOutput("t4_err", selErr2, 1);
    checkOutput("t4_sel_keep", selCur2, 0);
    checkOutput("t4_no_pend", selReqReady2, 1);
    nextCycle(); #1;
    checkOutput("t4_err_once", selErr2, 0);
    selReq2 = 2'd2; selReqValid2 = 1'b1;
    nextCycle();
    selReqValid2 = 1'b0;
    #1;
    checkOutput("t4_gap", inReady2, 3'b000);
    checkOutput("t4_pend", selReqReady2, 0);
    nextCycle();
    inData2[47:32] = 16'hBEEF; inValid2 = 3'b100; inLast2 = 3'b100;
    #1;
    checkOutput("t4_sel2", selCur2, 2);
    checkOutput("t4_rdy2", inReady2, 3'b100);
    checkOutput("t4_req_free", selReqReady2, 1);
    nextCycle();
    inValid2 = 3'b000; inLast2 = 3'b000;
    #1;
    checkOutput("t4_data", outData2, 16'hBEEF);
    checkOutput("t4_last", outLast2, 1);

    // reset in the middle of an open bank1 packet with a request pending
    nextCycle();
    inValid1 = 2'b10; inLast1 = 2'b00; inData1[1023:512] = makeBeat(32'h400);
    nextCycle();
    selReq1 = 1'b0; selReqValid1 = 1'b1;
    nextCycle();
    #1;
    checkOutput("t5_pend", selReqReady1, 0);
    checkOutput("t5_open", outValid1, 1);
    rst = 1'b1; inValid1 = 2'b00; selReqValid1 = 1'b0;
    nextCycle();
    rst = 1'b0;
    #1;
    checkOutput("t5_valid", outValid1, 0);
    checkOutput("t5_last", outLast1, 0);
    checkOutput("t5_data", outData1, 0);
    checkOutput("t5_sel", selCur1, 0);
    checkOutput("t5_req_rdy", selReqReady1, 1);
    checkOutput("t5_cnt", pktCount1, 0);
    checkOutput("t5_rdy", inReady1, 2'b01);
    nextCycle(); #1;
    checkOutput("t5_idle_rdy", inReady1, 2'b01);
    checkOutput("t5_idle_sel", selCur1, 0);

    // 65537 single-beat packets wrap the counter to 1 when it is built
    inValid1 = 2'b01; inLast1 = 2'b01; outReady1 = 1'b1;
    repeat (65537) nextCycle();
    inValid1 = 2'b00; inLast1 = 2'b00;
    repeat (2) nextCycle();
    #1;
`ifdef BANK_STREAM_MUX_PKT_CNT_EN
    checkOutput("t6_pkt_count", pktCount1, 16'd1);
`else
    checkOutput("t6_pkt_count", pktCount1, 16'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
